// File: rtl/mem_stage_if.sv
// mem_stage_if: EX->MEM->WB pipeline buses and data-cache request/response signals of the memory stage
interface mem_stage_if #(parameter int CSR_W = 47);
    logic             flush;
    logic             left_valid;
    logic             left_ready;
    logic             right_valid;
    logic             right_ready;
    logic [135:0]     ex_ctrl_bus;
    logic [4:0]       ex_mem_op;
    logic [31:0]      ex_store_data;
    logic [17:0]      ex_excp_bus;
    logic [CSR_W-1:0] ex_csr_bus;
    logic             dcache_req;
    logic             dcache_wr;
    logic [1:0]       dcache_size;
    logic [31:0]      dcache_addr;
    logic [31:0]      dcache_wdata;
    logic [3:0]       dcache_wstrb;
    logic             dcache_addr_ok;
    logic             dcache_data_ok;
    logic [31:0]      dcache_rdata;
    logic [135:0]     mem_ctrl_bus;
    logic [17:0]      mem_excp_bus;
    logic [CSR_W-1:0] mem_csr_bus;
    logic [37:0]      mem_bypass;
    logic             mem_load_pending;

    modport slave (
        input  flush, left_valid, right_ready, ex_ctrl_bus, ex_mem_op, ex_store_data, ex_excp_bus, ex_csr_bus,
        input  dcache_addr_ok, dcache_data_ok, dcache_rdata,
        output left_ready, right_valid, dcache_req, dcache_wr, dcache_size, dcache_addr, dcache_wdata, dcache_wstrb,
        output mem_ctrl_bus, mem_excp_bus, mem_csr_bus, mem_bypass, mem_load_pending
    );

    modport master (
        output flush, left_valid, right_ready, ex_ctrl_bus, ex_mem_op, ex_store_data, ex_excp_bus, ex_csr_bus,
        output dcache_addr_ok, dcache_data_ok, dcache_rdata,
        input  left_ready, right_valid, dcache_req, dcache_wr, dcache_size, dcache_addr, dcache_wdata, dcache_wstrb,
        input  mem_ctrl_bus, mem_excp_bus, mem_csr_bus, mem_bypass, mem_load_pending
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage issuing one dcache request per instruction, aligning loads and flagging ALE
module mem_stage #(parameter int CSR_W = 47) (
    input logic       clk,
    input logic       reset,
    mem_stage_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t           state, state_n;
    logic             valid;
    logic [135:0]     ctrl;
    logic [4:0]       op;
    logic [31:0]      sdata, result, ea, ex_ea, ld_data;
    logic [17:0]      excp;
    logic [CSR_W-1:0] csr;
    logic [15:0]      lane;
    logic [1:0]       ex_size;
    logic             cap, ale, go_req;

    assign ex_ea   = bus.ex_ctrl_bus[31:0];
    assign ex_size = bus.ex_mem_op[1:0];
    assign ale     = bus.ex_mem_op[4] & ((ex_size == 2'b01 & ex_ea[0]) | (ex_size == 2'b10 & ex_ea[1:0] != 2'b00));
    assign cap     = bus.left_valid & bus.left_ready & !bus.flush;
    assign go_req  = bus.ex_mem_op[4] & !bus.ex_excp_bus[0] & !ale;
    assign ea      = ctrl[31:0];
    assign lane    = 16'(bus.dcache_rdata >> {ea[1:0], 3'b000});
    assign ld_data = op[1:0] == 2'b00 ? {{24{!op[2] & lane[7]}}, lane[7:0]} :
                     op[1:0] == 2'b01 ? {{16{!op[2] & lane[15]}}, lane[15:0]} : bus.dcache_rdata;

    // A flush in WAIT that coincides with data_ok has already consumed the response, so it skips DRAIN
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = cap ? (go_req ? REQ : DONE) : IDLE;
            REQ:     state_n = bus.flush ? (bus.dcache_addr_ok ? DRAIN : IDLE) : (bus.dcache_addr_ok ? WAIT : REQ);
            WAIT:    state_n = bus.dcache_data_ok ? (bus.flush ? IDLE : DONE) : (bus.flush ? DRAIN : WAIT);
            DONE:    state_n = bus.flush ? IDLE : cap ? (go_req ? REQ : DONE) : (bus.right_ready ? IDLE : DONE);
            DRAIN:   state_n = bus.dcache_data_ok ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            valid  <= 1'b0;
            ctrl   <= '0;
            op     <= '0;
            sdata  <= '0;
            excp   <= '0;
            csr    <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            valid <= state_n inside {REQ, WAIT, DONE};
            if (cap) begin
                ctrl   <= ale ? {ex_ea, bus.ex_ctrl_bus[103:0]} : bus.ex_ctrl_bus;
                op     <= bus.ex_mem_op;
                sdata  <= bus.ex_store_data;
                excp   <= bus.ex_excp_bus | {7'b0, ale, 9'b0, ale};
                csr    <= bus.ex_csr_bus;
                result <= ex_ea;
            end else if (state == WAIT && bus.dcache_data_ok && !bus.flush && !op[3]) begin
                result <= ld_data;
            end
        end
    end

    assign bus.right_valid      = valid & state == DONE;
    assign bus.left_ready       = state == IDLE | (state == DONE & bus.right_ready);
    assign bus.dcache_req       = state == REQ;
    assign bus.dcache_wr        = op[3];
    assign bus.dcache_size      = op[1:0];
    assign bus.dcache_addr      = ea;
    assign bus.dcache_wdata     = op[1:0] == 2'b00 ? {4{sdata[7:0]}} : op[1:0] == 2'b01 ? {2{sdata[15:0]}} : sdata;
    assign bus.dcache_wstrb     = !op[3] ? 4'b0000 : op[1:0] == 2'b00 ? 4'b0001 << ea[1:0] :
                                  op[1:0] == 2'b01 ? 4'b0011 << {ea[1], 1'b0} : 4'b1111;
    assign bus.mem_ctrl_bus     = {ctrl[135:103], ctrl[102] & valid, ctrl[101:32], result};
    assign bus.mem_excp_bus     = excp;
    assign bus.mem_csr_bus      = csr;
    assign bus.mem_bypass       = {result, ctrl[101:97], ctrl[96] & valid & state == DONE};
    assign bus.mem_load_pending = valid & op[4] & !op[3] & state != DONE;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a behavioural reference model and a randomized dcache responder
module tb_mem_stage;
    localparam int CSR_W = 47;

    typedef struct {
        logic [135:0]     ctrl;
        logic [4:0]       op;
        logic [31:0]      sd;
        logic [17:0]      excp;
        logic [CSR_W-1:0] csr;
        logic [31:0]      rdata;
    } ins_t;

    typedef struct {
        logic [135:0]     ctrl;
        logic [17:0]      excp;
        logic [CSR_W-1:0] csr;
        logic [37:0]      byp;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if #(.CSR_W(CSR_W)) bus();
    mem_stage #(.CSR_W(CSR_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] rdata_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          rd1 = -1;
    int          rd2 = -1;
    logic        rr_rand = 1'b0;
    logic        rr_d = 1'b1;
    logic        rr_r = 1'b1;

    assign bus.right_ready = rr_rand ? rr_r : rr_d;

    task automatic chk(input string name, input logic [135:0] got, input logic [135:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: what WB must see and what the cache must be asked, from the architectural rules
    function automatic void model(input ins_t i, output exp_t e, output bit issue, output req_t r);
        int          n;
        logic [31:0] a, res, mask;
        bit          ale;
        n     = i.op[1:0] == 2'd0 ? 1 : i.op[1:0] == 2'd1 ? 2 : 4;
        a     = i.ctrl[31:0];
        ale   = i.op[4] && (a % n) != 0;
        issue = i.op[4] && !i.excp[0] && !ale;
        mask  = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        res   = a;
        if (issue && !i.op[3]) begin
            res = (i.rdata >> (8 * (a % 4))) & mask;
            if (!i.op[2] && n < 4 && res[8 * n - 1]) res = res | ~mask;
        end
        e.ctrl = i.ctrl;
        if (ale) e.ctrl[135:104] = a;
        e.ctrl[31:0] = res;
        e.excp  = i.excp | (ale ? 18'h00401 : 18'h0);
        e.csr   = i.csr;
        e.byp   = {res, i.ctrl[101:97], i.ctrl[96]};
        r.wr    = i.op[3];
        r.size  = i.op[1:0];
        r.addr  = a;
        r.wstrb = i.op[3] ? 4'(((1 << n) - 1) << (a % 4)) : 4'h0;
        r.wdata = n == 1 ? {24'h0, i.sd[7:0]} * 32'h0101_0101 : n == 2 ? {16'h0, i.sd[15:0]} * 32'h0001_0001 : i.sd;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.ctrl = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
        if ($urandom_range(0, 1) == 0) i.ctrl[1:0] = 2'b00;
        i.op    = {$urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2))};
        i.sd    = $urandom;
        i.excp  = {17'($urandom), $urandom_range(0, 7) == 0};
        i.csr   = {15'($urandom), $urandom};
        i.rdata = $urandom;
        return i;
    endfunction

    task automatic expect_ins(input ins_t i, input bit keep);
        exp_t e;
        req_t r;
        bit   issue;
        model(i, e, issue, r);
        if (keep) exp_q.push_back(e);
        if (issue) begin
            req_q.push_back(r);
            rdata_q.push_back(i.rdata);
        end
    endtask

    task automatic drive(input ins_t i);
        bus.ex_ctrl_bus   = i.ctrl;
        bus.ex_mem_op     = i.op;
        bus.ex_store_data = i.sd;
        bus.ex_excp_bus   = i.excp;
        bus.ex_csr_bus    = i.csr;
    endtask

    task automatic send(input ins_t i, input bit keep);
        int t;
        expect_ins(i, keep);
        drive(i);
        bus.left_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.left_ready && t < 200);
        if (!bus.left_ready) begin
            n_err++;
            $display("FAIL capture_timeout: left_ready stayed 0 for %0d cycles", t);
        end
        @(posedge clk); #1;
        bus.left_valid = 1'b0;
    endtask

    task automatic wait_rv(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.right_valid && t < 20);
        chk(name, bus.right_valid, 1);
        @(posedge clk); #1;
    endtask

    // dcache model: accepts a pending request after rd1 cycles, returns data rd2 cycles later (random if negative)
    initial begin
        bus.dcache_addr_ok = 1'b0;
        bus.dcache_data_ok = 1'b0;
        bus.dcache_rdata   = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset && bus.dcache_req) begin
                int          a, d;
                logic [31:0] rd;
                a  = rd1 < 0 ? $urandom_range(0, 2) : rd1;
                d  = rd2 < 0 ? $urandom_range(0, 2) : rd2;
                rd = rdata_q.size() != 0 ? rdata_q.pop_front() : 32'h0;
                repeat (a) begin @(posedge clk); #1; end
                bus.dcache_addr_ok = 1'b1;
                @(posedge clk); #1;
                bus.dcache_addr_ok = 1'b0;
                repeat (d) begin @(posedge clk); #1; end
                bus.dcache_data_ok = 1'b1;
                bus.dcache_rdata   = rd;
                @(posedge clk); #1;
                bus.dcache_data_ok = 1'b0;
                bus.dcache_rdata   = $urandom;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rr_r = $urandom_range(0, 3) != 0;
    end

    // Monitor: request fields against the expected request, WB handoffs against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.dcache_req) begin
                if (req_q.size() == 0) chk("req_spurious", bus.dcache_req, 0);
                else begin
                    chk("req_addr", bus.dcache_addr, req_q[0].addr);
                    chk("req_wr", bus.dcache_wr, req_q[0].wr);
                    chk("req_size", bus.dcache_size, req_q[0].size);
                    chk("req_wstrb", bus.dcache_wstrb, req_q[0].wstrb);
                    if (req_q[0].wr) chk("req_wdata", bus.dcache_wdata, req_q[0].wdata);
                    if (bus.dcache_addr_ok) req_q.delete(0);
                end
            end
            if (!reset && bus.right_valid && bus.right_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", bus.right_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("mem_ctrl_bus", bus.mem_ctrl_bus, e.ctrl);
                    chk("mem_excp_bus", bus.mem_excp_bus, e.excp);
                    chk("mem_csr_bus", bus.mem_csr_bus, e.csr);
                    chk("mem_bypass", bus.mem_bypass, e.byp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t i, j;
        exp_t e, ej;
        req_t r;
        bit   issue;
        int   t;
        bus.flush      = 1'b0;
        bus.left_valid = 1'b0;
        drive('{default: '0});
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_right_valid", bus.right_valid, 0);
        chk("rst_left_ready", bus.left_ready, 1);
        chk("rst_dcache_req", bus.dcache_req, 0);
        chk("rst_ctrl", bus.mem_ctrl_bus, 0);
        chk("rst_excp", bus.mem_excp_bus, 0);
        chk("rst_csr", bus.mem_csr_bus, 0);
        chk("rst_bypass", bus.mem_bypass, 0);
        chk("rst_load_pending", bus.mem_load_pending, 0);
        @(posedge clk); #1;

        i = rnd_ins(); i.op = 5'b00010; i.ctrl[31:0] = 32'h1234; i.ctrl[96] = 1'b1; i.excp = '0;
        send(i, 1);
        @(negedge clk);
        chk("nonmem_rv", bus.right_valid, 1);
        chk("nonmem_result", bus.mem_ctrl_bus[31:0], 32'h1234);
        chk("nonmem_byp_en", bus.mem_bypass[0], 1);
        chk("nonmem_req", bus.dcache_req, 0);
        @(posedge clk); #1;

        rd1 = 0; rd2 = 0;
        i = rnd_ins(); i.op = 5'b10000; i.ctrl[31:0] = 32'h1003; i.excp = '0; i.rdata = 32'h80FF_FF00;
        send(i, 1);
        @(negedge clk);
        chk("ldb_req", bus.dcache_req, 1);
        chk("ldb_pending_req", bus.mem_load_pending, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldb_pending_wait", bus.mem_load_pending, 1);
        chk("ldb_rv_early", bus.right_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ldb_rv", bus.right_valid, 1);
        chk("ldb_result", bus.mem_ctrl_bus[31:0], 32'hFFFF_FF80);
        chk("ldb_pending_done", bus.mem_load_pending, 0);
        @(posedge clk); #1;

        rd1 = 1; rd2 = 1;
        i = rnd_ins(); i.op = 5'b11001; i.ctrl[31:0] = 32'h2002; i.sd = 32'hABCD_1234; i.excp = '0;
        send(i, 1);
        @(negedge clk);
        chk("sth_wr", bus.dcache_wr, 1);
        chk("sth_wstrb", bus.dcache_wstrb, 4'b1100);
        chk("sth_wdata", bus.dcache_wdata, 32'h1234_1234);
        wait_rv("sth_rv");

        i = rnd_ins(); i.op = 5'b10010; i.ctrl[31:0] = 32'h3001; i.excp = '0;
        send(i, 1);
        @(negedge clk);
        chk("ale_rv", bus.right_valid, 1);
        chk("ale_req", bus.dcache_req, 0);
        chk("ale_excp", {bus.mem_excp_bus[10], bus.mem_excp_bus[0]}, 2'b11);
        chk("ale_addr", bus.mem_ctrl_bus[135:104], 32'h3001);
        @(posedge clk); #1;

        rd1 = 0; rd2 = 3;
        i = rnd_ins(); i.op = 5'b10010; i.ctrl[31:0] = 32'h4000; i.excp = '0;
        send(i, 0);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        j = rnd_ins(); j.op = 5'b00000;
        expect_ins(j, 1);
        drive(j);
        bus.left_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_left_ready", bus.left_ready, 0);
            chk("drain_right_valid", bus.right_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_exit_left_ready", bus.left_ready, 1);
        @(posedge clk); #1;
        bus.left_valid = 1'b0;
        @(negedge clk);
        chk("drain_next_rv", bus.right_valid, 1);
        @(posedge clk); #1;

        rd1 = -1; rd2 = -1; rr_d = 1'b0;
        i = rnd_ins(); i.op = 5'b00001;
        model(i, e, issue, r);
        send(i, 1);
        j = rnd_ins(); j.op = 5'b00000;
        model(j, ej, issue, r);
        drive(j);
        bus.left_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_rv", bus.right_valid, 1);
            chk("stall_left_ready", bus.left_ready, 0);
            chk("stall_ctrl", bus.mem_ctrl_bus, e.ctrl);
            @(posedge clk); #1;
        end
        expect_ins(j, 1);
        rr_d = 1'b1;
        @(negedge clk);
        chk("release_left_ready", bus.left_ready, 1);
        @(posedge clk); #1;
        bus.left_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rv", bus.right_valid, 1);
        chk("b2b_ctrl", bus.mem_ctrl_bus, ej.ctrl);
        @(posedge clk); #1;

        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(rnd_ins(), 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        t = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d results and %0d requests still outstanding", exp_q.size(), req_q.size());
        end
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
